// File: rtl/sprite_overlay_pkg.sv
// -----------------------------------------------------------------------------
// sprite_overlay_pkg
//   Shared types and helpers for the sprite overlay.
//   - Default width localparams for the overlay datapath.
//   - sprite_cfg_t: one sprite's configuration record at the default widths
//     (field order {x, y, w, h, rgb, en, blink[, alpha]}).
//   - lowest_set(): isolates the lowest set bit of a request vector, which
//     implements "lower index wins" priority selection.
//   Optional feature macro: SPRITE_ALPHA_EN adds the per-sprite alpha bit.
// -----------------------------------------------------------------------------
package sprite_overlay_pkg;

    localparam int DEF_COORD_W = 11;
    localparam int DEF_COLOR_W = 8;
    localparam int DEF_SIZE_W  = 7;
    localparam int MAX_SPRITES = 16;

    typedef struct packed {
        logic [DEF_COORD_W-1:0]   x;
        logic [DEF_COORD_W-1:0]   y;
        logic [DEF_SIZE_W-1:0]    w;
        logic [DEF_SIZE_W-1:0]    h;
        logic [3*DEF_COLOR_W-1:0] rgb;
        logic                     en;
        logic                     blink;
`ifdef SPRITE_ALPHA_EN
        logic                     alpha;
`endif
    } sprite_cfg_t;

    // One-hot of the lowest set bit: v & -v. Bit 0 has the highest priority.
    function automatic logic [MAX_SPRITES-1:0] lowest_set(input logic [MAX_SPRITES-1:0] v);
        return v & (~v + MAX_SPRITES'(1));
    endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// -----------------------------------------------------------------------------
// sprite_hit_unit
//   Combinational rectangle test for one sprite.
//   Ports:
//     x, y    in  COORD_W  pixel coordinate under test
//     sx, sy  in  COORD_W  sprite top-left corner
//     w, h    in  SIZE_W   sprite size (0 = never hit)
//     en      in  1        sprite enable
//     hit     out 1        en && sx <= x < sx+w && sy <= y < sy+h
//   The right/bottom edges are formed one bit wider than the coordinates so a
//   sprite running off the end of the coordinate range is clipped instead of
//   wrapping around to column/row 0.
// -----------------------------------------------------------------------------
module sprite_hit_unit #(
    parameter int COORD_W = 11,
    parameter int SIZE_W  = 7
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    input  logic [SIZE_W-1:0]  w,
    input  logic [SIZE_W-1:0]  h,
    input  logic               en,
    output logic               hit
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end = {1'b0, sx} + (COORD_W+1)'(w);
    assign y_end = {1'b0, sy} + (COORD_W+1)'(h);

    assign hit = en
              && (x >= sx) && ({1'b0, x} < x_end)
              && (y >= sy) && ({1'b0, y} < y_end);

endmodule

// File: rtl/sprite_overlay.sv
// -----------------------------------------------------------------------------
// sprite_overlay
//   Composites N_SPRITES rectangles over a background pixel stream. Each sprite
//   has a shadow configuration (written at any time) and an active one (used
//   for drawing), copied shadow -> active on frame_start so a frame never shows
//   a half-updated sprite. Fixed 2-cycle latency from x/y/bg to out_*.
//
//   Ports:
//     CLOCK_50                   in   system clock
//     reset                      in   synchronous active-high reset
//     x_coord, y_coord           in   current pixel position
//     frame_start                in   commit pulse (shadow -> active)
//     bg_R, bg_G, bg_B           in   background colour for this pixel
//     cfg_we, cfg_idx            in   shadow write strobe / target sprite
//     cfg_x, cfg_y, cfg_w, cfg_h in   rectangle (w or h of 0 = never hit)
//     cfg_rgb                    in   sprite colour {R,G,B}
//     cfg_en, cfg_blink          in   enable / blink flags
//     cfg_alpha                  in   50% blend flag (SPRITE_ALPHA_EN only)
//     out_R, out_G, out_B        out  composited colour
//     out_hit                    out  per-sprite visible hits, aligned with out_*
//
//   Optional feature macro: SPRITE_ALPHA_EN (per-sprite 50% blend with bg).
// -----------------------------------------------------------------------------
module sprite_overlay
    import sprite_overlay_pkg::*;
#(
    parameter int N_SPRITES = 4,
    parameter int COORD_W   = 11,
    parameter int COLOR_W   = 8,
    parameter int SIZE_W    = 7,
    parameter int BLINK_DIV = 25000000,
    localparam int IDX_W    = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   x_coord,
    input  logic [COORD_W-1:0]   y_coord,
    input  logic                 frame_start,
    input  logic [COLOR_W-1:0]   bg_R,
    input  logic [COLOR_W-1:0]   bg_G,
    input  logic [COLOR_W-1:0]   bg_B,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [COORD_W-1:0]   cfg_x,
    input  logic [COORD_W-1:0]   cfg_y,
    input  logic [SIZE_W-1:0]    cfg_w,
    input  logic [SIZE_W-1:0]    cfg_h,
    input  logic [3*COLOR_W-1:0] cfg_rgb,
    input  logic                 cfg_en,
    input  logic                 cfg_blink,
`ifdef SPRITE_ALPHA_EN
    input  logic                 cfg_alpha,
`endif
    output logic [COLOR_W-1:0]   out_R,
    output logic [COLOR_W-1:0]   out_G,
    output logic [COLOR_W-1:0]   out_B,
    output logic [N_SPRITES-1:0] out_hit
);

    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam int RGB_W = 3 * COLOR_W;

    // Same layout as sprite_cfg_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SIZE_W-1:0]  w;
        logic [SIZE_W-1:0]  h;
        logic [RGB_W-1:0]   rgb;
        logic               en;
        logic               blink;
`ifdef SPRITE_ALPHA_EN
        logic               alpha;
`endif
    } cfg_t;

    cfg_t cfg_new;
    cfg_t shadow [N_SPRITES];
    cfg_t active [N_SPRITES];

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        cfg_new       = '0;
        cfg_new.x     = cfg_x;
        cfg_new.y     = cfg_y;
        cfg_new.w     = cfg_w;
        cfg_new.h     = cfg_h;
        cfg_new.rgb   = cfg_rgb;
        cfg_new.en    = cfg_en;
        cfg_new.blink = cfg_blink;
`ifdef SPRITE_ALPHA_EN
        cfg_new.alpha = cfg_alpha;
`endif
    end

    // Shadow/active register sets. A write coinciding with frame_start goes
    // straight through to active as well, so it is not lost for a frame.
    // Out-of-range cfg_idx matches no sprite and the write is dropped.
    // NOTE: these are flop arrays, not RAM, and are reset so every sprite
    // starts disabled; a RAM-style memory would be left unreset.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (cfg_we && (int'(cfg_idx) == i)) begin
                    shadow[i] <= cfg_new;
                end
                if (frame_start) begin
                    active[i] <= (cfg_we && (int'(cfg_idx) == i)) ? cfg_new : shadow[i];
                end
            end
        end
    end

    // Blink timebase: phase toggles every BLINK_DIV clocks.
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + CNT_W'(1);
        end
    end

    // Per-sprite rectangle compare against the active configuration.
    logic [N_SPRITES-1:0] raw_hit;

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_hit
        sprite_hit_unit #(
            .COORD_W (COORD_W),
            .SIZE_W  (SIZE_W)
        ) u_hit (
            .x   (x_coord),
            .y   (y_coord),
            .sx  (active[g].x),
            .sy  (active[g].y),
            .w   (active[g].w),
            .h   (active[g].h),
            .en  (active[g].en),
            .hit (raw_hit[g])
        );
    end

    // Stage 1: raw hits and background.
    logic [N_SPRITES-1:0] hit_s1;
    logic [RGB_W-1:0]     bg_s1;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hit_s1 <= '0;
            bg_s1  <= '0;
        end else begin
            hit_s1 <= raw_hit;
            bg_s1  <= {bg_R, bg_G, bg_B};
        end
    end

    // Stage 2: blink masking, priority select, colour mux.
    logic [N_SPRITES-1:0] vis;
    logic [N_SPRITES-1:0] sel;
    logic [RGB_W-1:0]     spr_rgb;
    logic [RGB_W-1:0]     next_rgb;
`ifdef SPRITE_ALPHA_EN
    logic                 spr_alpha;
    logic [RGB_W-1:0]     blend_rgb;
    logic [COLOR_W:0]     ch_sum;
`endif

    always_comb begin
        vis      = '0;
        spr_rgb  = '0;
        next_rgb = bg_s1;
`ifdef SPRITE_ALPHA_EN
        spr_alpha = 1'b0;
        blend_rgb = '0;
        ch_sum    = '0;
`endif
        for (int i = 0; i < N_SPRITES; i++) begin
            vis[i] = hit_s1[i] & (~active[i].blink | blink_phase);
        end

        sel = N_SPRITES'(lowest_set(MAX_SPRITES'(vis)));

        // sel is one-hot or zero, so an AND-OR mux picks the winner.
        for (int i = 0; i < N_SPRITES; i++) begin
            if (sel[i]) begin
                spr_rgb = spr_rgb | active[i].rgb;
`ifdef SPRITE_ALPHA_EN
                spr_alpha = spr_alpha | active[i].alpha;
`endif
            end
        end

`ifdef SPRITE_ALPHA_EN
        // Average per channel with one extra bit so the carry is kept.
        for (int c = 0; c < 3; c++) begin
            ch_sum = {1'b0, spr_rgb[c*COLOR_W +: COLOR_W]} + {1'b0, bg_s1[c*COLOR_W +: COLOR_W]};
            blend_rgb[c*COLOR_W +: COLOR_W] = ch_sum[COLOR_W:1];
        end
        if (|sel) begin
            next_rgb = spr_alpha ? blend_rgb : spr_rgb;
        end
`else
        if (|sel) begin
            next_rgb = spr_rgb;
        end
`endif
    end

    logic [RGB_W-1:0] out_rgb;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            out_rgb <= '0;
            out_hit <= '0;
        end else begin
            out_rgb <= next_rgb;
            out_hit <= vis;
        end
    end

    assign out_R = out_rgb[3*COLOR_W-1:2*COLOR_W];
    assign out_G = out_rgb[2*COLOR_W-1:COLOR_W];
    assign out_B = out_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_sprite_overlay.sv
// -----------------------------------------------------------------------------
// tb_sprite_overlay
//   Scoreboard bench for sprite_overlay (N_SPRITES=4, BLINK_DIV=4). Each pixel
//   driven pushes its expected colour/hit vector, computed from a behavioural
//   model of the shadow/active registers and blink timebase; the entry is
//   popped and compared two clocks later. Inputs are driven and outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sprite_overlay;
    import sprite_overlay_pkg::*;

    localparam int N   = 4;
    localparam int CW  = 11;
    localparam int DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic [CW-1:0] x_coord = '0;
    logic [CW-1:0] y_coord = '0;
    logic          frame_start = 1'b0;
    logic [7:0]    bg_R = '0, bg_G = '0, bg_B = '0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_idx = '0;
    logic [CW-1:0] cfg_x = '0, cfg_y = '0;
    logic [6:0]    cfg_w = '0, cfg_h = '0;
    logic [23:0]   cfg_rgb = '0;
    logic          cfg_en = 1'b0, cfg_blink = 1'b0;
`ifdef SPRITE_ALPHA_EN
    logic          cfg_alpha = 1'b0;
`endif
    logic [7:0]    out_R, out_G, out_B;
    logic [N-1:0]  out_hit;

    sprite_overlay #(
        .N_SPRITES (N),
        .COORD_W   (CW),
        .COLOR_W   (8),
        .SIZE_W    (7),
        .BLINK_DIV (DIV)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .frame_start (frame_start),
        .bg_R        (bg_R),
        .bg_G        (bg_G),
        .bg_B        (bg_B),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .cfg_w       (cfg_w),
        .cfg_h       (cfg_h),
        .cfg_rgb     (cfg_rgb),
        .cfg_en      (cfg_en),
        .cfg_blink   (cfg_blink),
`ifdef SPRITE_ALPHA_EN
        .cfg_alpha   (cfg_alpha),
`endif
        .out_R       (out_R),
        .out_G       (out_G),
        .out_B       (out_B),
        .out_hit     (out_hit)
    );

    typedef struct packed {
        logic [23:0]  rgb;
        logic [N-1:0] hit;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    sprite_cfg_t m_shadow [N];
    sprite_cfg_t m_active [N];
    int          m_cnt = 0;
    logic        m_phase = 1'b0;

    // Blink timebase model: 0..DIV-1, phase toggles on wrap.
    always @(posedge clk) begin
        if (reset) begin
            m_cnt   <= 0;
            m_phase <= 1'b0;
        end else if (m_cnt == DIV - 1) begin
            m_cnt   <= 0;
            m_phase <= ~m_phase;
        end else begin
            m_cnt   <= m_cnt + 1;
        end
    end

    // Phase that will be in effect while a pixel driven now is in stage 2.
    function automatic logic ph_next();
        return (m_cnt == DIV - 1) ? ~m_phase : m_phase;
    endfunction

    function automatic exp_t model(input int x, input int y, input logic [23:0] bg, input logic ph);
        exp_t e;
        bit   found;
        e.rgb = bg;
        e.hit = '0;
        found = 0;
        for (int i = 0; i < N; i++) begin
            if (m_active[i].en
                && x >= int'(m_active[i].x) && x < int'(m_active[i].x) + int'(m_active[i].w)
                && y >= int'(m_active[i].y) && y < int'(m_active[i].y) + int'(m_active[i].h)
                && (!m_active[i].blink || ph)) begin
                e.hit[i] = 1'b1;
                if (!found) begin
                    found = 1;
                    e.rgb = m_active[i].rgb;
                end
            end
        end
        return e;
    endfunction

    task automatic put_pixel(input int x, input int y, input logic [23:0] bg);
        x_coord = CW'(x);
        y_coord = CW'(y);
        {bg_R, bg_G, bg_B} = bg;
        sb.push_back(model(x, y, bg, ph_next()));
    endtask

    task automatic cfg_write(input int idx, input int x, input int y, input int w, input int h,
                             input logic [23:0] rgb, input logic blink, input logic commit);
        sprite_cfg_t c;
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_idx     = 2'(idx);
        cfg_x       = CW'(x);
        cfg_y       = CW'(y);
        cfg_w       = 7'(w);
        cfg_h       = 7'(h);
        cfg_rgb     = rgb;
        cfg_en      = 1'b1;
        cfg_blink   = blink;
        frame_start = commit;
        @(negedge clk);
        cfg_we      = 1'b0;
        frame_start = 1'b0;
        c       = '0;
        c.x     = CW'(x);
        c.y     = CW'(y);
        c.w     = 7'(w);
        c.h     = 7'(h);
        c.rgb   = rgb;
        c.en    = 1'b1;
        c.blink = blink;
        m_shadow[idx] = c;
        if (commit) for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    endtask

    task automatic do_commit();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    endtask

    task automatic test_reset();
        int xs [8] = '{0, 100, 639, 2047, 5, 320, 1000, 2046};
        int ys [8] = '{0, 240, 479, 2047, 7, 12, 1500, 3};
        reset = 1'b1;
        {bg_R, bg_G, bg_B} = 24'h808080;
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_R, out_G, out_B} !== 24'h0 || out_hit !== '0) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d: got rgb=%h hit=%b, want rgb=000000 hit=0000",
                         k, {out_R, out_G, out_B}, out_hit);
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if ({out_R, out_G, out_B} !== 24'h0 || out_hit !== '0) begin
                    n_bad++;
                    $display("FAIL reset_tail: got rgb=%h hit=%b, want rgb=000000 hit=0000",
                             {out_R, out_G, out_B}, out_hit);
                end
            end
            if (k >= 2) begin
                exp_t e = sb.pop_front();
                n_cmp++;
                if ({out_R, out_G, out_B} !== e.rgb || out_hit !== e.hit) begin
                    n_bad++;
                    $display("FAIL bg_sweep px%0d: got rgb=%h hit=%b, want rgb=%h hit=%b",
                             k - 2, {out_R, out_G, out_B}, out_hit, e.rgb, e.hit);
                end
            end
            if (k == 0) reset = 1'b0;
            if (k < 8) put_pixel(xs[k], ys[k], 24'h808080);
        end
    endtask

    task automatic test_single_sprite();
        int xs [9] = '{10, 11, 12, 13, 10, 13, 14, 10, 9};
        int ys [9] = '{20, 21, 22, 23, 23, 20, 20, 19, 21};
        cfg_write(0, 10, 20, 4, 4, 24'hFF0000, 1'b0, 1'b0);
        do_commit();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                exp_t e = sb.pop_front();
                n_cmp++;
                if ({out_R, out_G, out_B} !== e.rgb || out_hit !== e.hit) begin
                    n_bad++;
                    $display("FAIL single px%0d: got rgb=%h hit=%b, want rgb=%h hit=%b",
                             k - 2, {out_R, out_G, out_B}, out_hit, e.rgb, e.hit);
                end
            end
            if (k < 9) put_pixel(xs[k], ys[k], 24'($urandom));
        end
    endtask

    task automatic test_overlap();
        int xs [6] = '{10, 13, 14, 17, 18, 9};
        int ys [6] = '{10, 13, 14, 17, 18, 10};
        cfg_write(0, 10, 10, 4, 4, 24'hFF0000, 1'b0, 1'b0);
        cfg_write(1, 10, 10, 8, 8, 24'h00FF00, 1'b0, 1'b0);
        do_commit();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                exp_t e = sb.pop_front();
                n_cmp++;
                if ({out_R, out_G, out_B} !== e.rgb || out_hit !== e.hit) begin
                    n_bad++;
                    $display("FAIL overlap px%0d: got rgb=%h hit=%b, want rgb=%h hit=%b",
                             k - 2, {out_R, out_G, out_B}, out_hit, e.rgb, e.hit);
                end
            end
            if (k < 6) put_pixel(xs[k], ys[k], 24'($urandom));
        end
    endtask

    task automatic test_shadow_commit();
        int xs [3] = '{10, 100, 103};
        int ys [3] = '{10, 100, 103};
        int cx [3] = '{200, 201, 202};
        int cy [3] = '{200, 201, 200};
        // Shadow write only: drawing must still use the old position.
        cfg_write(0, 100, 100, 4, 4, 24'hFF0000, 1'b0, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (k >= 2) begin
                    exp_t e = sb.pop_front();
                    n_cmp++;
                    if ({out_R, out_G, out_B} !== e.rgb || out_hit !== e.hit) begin
                        n_bad++;
                        $display("FAIL shadow pass%0d px%0d: got rgb=%h hit=%b, want rgb=%h hit=%b",
                                 pass, k - 2, {out_R, out_G, out_B}, out_hit, e.rgb, e.hit);
                    end
                end
                if (k < 3) put_pixel(xs[k], ys[k], 24'h123456);
            end
            if (pass == 0) do_commit();
        end
        // Write coincident with frame_start is committed at once.
        cfg_write(2, 200, 200, 2, 2, 24'h0000FF, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                exp_t e = sb.pop_front();
                n_cmp++;
                if ({out_R, out_G, out_B} !== e.rgb || out_hit !== e.hit) begin
                    n_bad++;
                    $display("FAIL write_through px%0d: got rgb=%h hit=%b, want rgb=%h hit=%b",
                             k - 2, {out_R, out_G, out_B}, out_hit, e.rgb, e.hit);
                end
            end
            if (k < 3) put_pixel(cx[k], cy[k], 24'h654321);
        end
    endtask

    task automatic test_blink();
        int seen_on  = 0;
        int seen_off = 0;
        cfg_write(3, 300, 300, 1, 1, 24'hFFFF00, 1'b1, 1'b1);
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                exp_t e = sb.pop_front();
                n_cmp++;
                if ({out_R, out_G, out_B} !== e.rgb || out_hit !== e.hit) begin
                    n_bad++;
                    $display("FAIL blink px%0d: got rgb=%h hit=%b, want rgb=%h hit=%b",
                             k - 2, {out_R, out_G, out_B}, out_hit, e.rgb, e.hit);
                end
                if (k % 2 == 0) begin
                    if (out_hit[3]) seen_on++;
                    else seen_off++;
                end
            end
            // Even slots probe the blinking sprite, odd slots the steady one.
            if (k < 24) begin
                if (k % 2 == 0) put_pixel(300, 300, 24'h202020);
                else put_pixel(200, 200, 24'h202020);
            end
        end
        n_cmp++;
        if (seen_on == 0 || seen_off == 0) begin
            n_bad++;
            $display("FAIL blink_toggle: got on=%0d off=%0d, want both nonzero", seen_on, seen_off);
        end
    endtask

    task automatic test_edge_clip();
        int xs [8] = '{2040, 2047, 2039, 0, 5, 11, 2047, 2044};
        int ys [8] = '{50, 53, 50, 50, 51, 50, 54, 52};
        cfg_write(1, 2040, 50, 20, 4, 24'h00FFFF, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                exp_t e = sb.pop_front();
                n_cmp++;
                if ({out_R, out_G, out_B} !== e.rgb || out_hit !== e.hit) begin
                    n_bad++;
                    $display("FAIL edge_clip px%0d: got rgb=%h hit=%b, want rgb=%h hit=%b",
                             k - 2, {out_R, out_G, out_B}, out_hit, e.rgb, e.hit);
                end
            end
            if (k < 8) put_pixel(xs[k], ys[k], 24'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_single_sprite();
        test_overlap();
        test_shadow_commit();
        test_blink();
        test_edge_clip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
